// File: rtl/duc_core.sv
// Digital up-converter: s = I*cos - Q*sin on a 3-register pipeline with a global
// enable, plus a linear amplitude ramp so that new I/Q targets do not splatter.
module duc_core #(
    parameter int RAMP_LOG2 = 4
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [31:0] s_axis_dds_tdata,
    input  logic        s_axis_dds_tvalid,
    output logic        s_axis_dds_tready,
    input  logic [31:0] s_axis_amp_tdata,
    input  logic        s_axis_amp_tvalid,
    output logic        s_axis_amp_tready,
    input  logic        resync,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        ramp_busy
);
    typedef enum logic {IDLE, RAMP} state_t;

    localparam bit IMMEDIATE = (RAMP_LOG2 == 0);
    localparam int CW = (RAMP_LOG2 > 0) ? RAMP_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << RAMP_LOG2) - 1);

    state_t state_q, state_d;
    logic   alive_q;
    logic   en, dds_acc, amp_acc, ramp_last;

    logic signed [15:0] cur_i_q, cur_q_q, tgt_i_q, tgt_q_q, step_i_q, step_q_q;
    logic signed [15:0] amp_i, amp_q;
    logic signed [16:0] diff_i, diff_q, sh_i, sh_q;
    logic [CW-1:0]      cnt_q;

    logic               s1_v_q, s2_v_q, m_v_q;
    logic signed [15:0] s1_cos_q, s1_sin_q, s1_i_q, s1_q_q;
    logic signed [31:0] p_i_q, p_q_q;
    logic signed [32:0] d, rnd, shr;
    logic signed [15:0] sat;
    logic [15:0]        m_data_q;

    // Valid/ready: a beat moves on a rising clk edge where tvalid & tready are both
    // high; tready never depends on the same interface's tvalid, and resync or the
    // first cycle out of reset forces both input treadys low.
    assign en                = ~m_v_q | m_axis_tready;
    assign s_axis_dds_tready = alive_q & en & ~resync;
    assign s_axis_amp_tready = alive_q & (state_q == IDLE) & ~resync;
    assign dds_acc           = s_axis_dds_tvalid & s_axis_dds_tready;
    assign amp_acc           = s_axis_amp_tvalid & s_axis_amp_tready;
    assign ramp_last         = (cnt_q == CNT_LAST);

    assign amp_i  = s_axis_amp_tdata[15:0];
    assign amp_q  = s_axis_amp_tdata[31:16];
    assign diff_i = {amp_i[15], amp_i} - {cur_i_q[15], cur_i_q};
    assign diff_q = {amp_q[15], amp_q} - {cur_q_q[15], cur_q_q};
    assign sh_i   = diff_i >>> RAMP_LOG2;
    assign sh_q   = diff_q >>> RAMP_LOG2;

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_v_q;
    assign ramp_busy     = (state_q == RAMP);

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (amp_acc && !IMMEDIATE) state_d = RAMP;
            RAMP: if (dds_acc && ramp_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (resync) state_d = IDLE;
    end

    // The ramp advances after the accepted sample has captured the old amplitude;
    // the final step snaps to the target so truncation error never accumulates.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            cur_i_q  <= '0;
            cur_q_q  <= '0;
            tgt_i_q  <= '0;
            tgt_q_q  <= '0;
            step_i_q <= '0;
            step_q_q <= '0;
            cnt_q    <= '0;
        end else if (resync) begin
            cur_i_q  <= '0;
            cur_q_q  <= '0;
            tgt_i_q  <= '0;
            tgt_q_q  <= '0;
            step_i_q <= '0;
            step_q_q <= '0;
            cnt_q    <= '0;
        end else if (amp_acc) begin
            tgt_i_q <= amp_i;
            tgt_q_q <= amp_q;
            cnt_q   <= '0;
            if (IMMEDIATE) begin
                cur_i_q <= amp_i;
                cur_q_q <= amp_q;
            end else begin
                step_i_q <= sh_i[15:0];
                step_q_q <= sh_q[15:0];
            end
        end else if (state_q == RAMP && dds_acc) begin
            cnt_q <= cnt_q + CW'(1);
            if (ramp_last) begin
                cur_i_q <= tgt_i_q;
                cur_q_q <= tgt_q_q;
            end else begin
                cur_i_q <= cur_i_q + step_i_q;
                cur_q_q <= cur_q_q + step_q_q;
            end
        end
    end

    always_comb begin
        d   = 33'(p_i_q) - 33'(p_q_q);
        rnd = d + 33'sd16384;
        shr = rnd >>> 15;
        sat = shr[15:0];
        if (shr > 33'sd32767)       sat = 16'sh7fff;
        else if (shr < -33'sd32768) sat = 16'sh8000;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            m_v_q    <= 1'b0;
            s1_cos_q <= '0;
            s1_sin_q <= '0;
            s1_i_q   <= '0;
            s1_q_q   <= '0;
            p_i_q    <= '0;
            p_q_q    <= '0;
            m_data_q <= '0;
        end else if (resync) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            m_v_q  <= 1'b0;
        end else if (en) begin
            s1_v_q <= dds_acc;
            if (dds_acc) begin
                s1_cos_q <= s_axis_dds_tdata[15:0];
                s1_sin_q <= s_axis_dds_tdata[31:16];
                s1_i_q   <= cur_i_q;
                s1_q_q   <= cur_q_q;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                p_i_q <= 32'(s1_i_q) * 32'(s1_cos_q);
                p_q_q <= 32'(s1_q_q) * 32'(s1_sin_q);
            end
            m_v_q <= s2_v_q;
            if (s2_v_q) m_data_q <= sat;
        end
    end
endmodule

// File: doc/duc_core.md
Name: duc_core

Overview:
- Digital up-converter. It is the transmit-side counterpart of the DDC, the probe-tone generator for one readout channel.
- Consumes complex DDS samples (cos/sin) and a complex baseband amplitude (I/Q). Produces a real 16-bit DAC sample s = I·cos − Q·sin.
- New amplitudes are applied through a linear ramp to avoid spectral splatter.
- Sits between the shared DDS and the DAC-side sample combiner.

Parameters:
- RAMP_LOG2, 4, ramp length is 2^RAMP_LOG2 accepted DDS samples; 0 means immediate load.
- LATENCY is fixed at 3 and is not a parameter.

Ports:
- s_axis_aclk  in  1  single clock for all logic
- s_axis_aresetn  in  1  asynchronous, active-low reset
- s_axis_dds_tdata  in  32  [15:0] cos, [31:16] sin, signed Q1.15
- s_axis_dds_tvalid  in  1  DDS sample valid
- s_axis_dds_tready  out  1  DDS sample accepted when tvalid&tready
- s_axis_amp_tdata  in  32  [15:0] I, [31:16] Q target amplitude, signed Q1.15
- s_axis_amp_tvalid  in  1  amplitude update valid
- s_axis_amp_tready  out  1  high only in IDLE
- resync  in  1  synchronous flush: clears pipeline and current amplitude
- m_axis_tdata  out  16  real output sample, signed Q1.15
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- ramp_busy  out  1  high while in RAMP

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - m_axis_tdata=0, m_axis_tvalid=0, ramp_busy=0, s_axis_amp_tready=0 for the first cycle, then 1.
  - Current amplitude cur_I=cur_Q=0, target 0, pipeline valids 0, FSM=IDLE.
- Pipeline:
  - 3 stages with one global enable: en = ~m_axis_tvalid | m_axis_tready. s_axis_dds_tready = en.
  - Stage 1: on DDS accept, register cos, sin, cur_I, cur_Q and valid.
  - Stage 2: products pI = I·cos and pQ = Q·sin, 32-bit signed.
  - Stage 3: d = pI − pQ (33-bit), r = (d + 2^14) >>> 15 arithmetic, saturate to [−32768, 32767].
  - Output registers: m_axis_tdata, m_axis_tvalid.
  - Latency is exactly 3 enabled cycles from DDS accept to m_axis_tvalid.
  - Bubbles propagate as tvalid=0.
  - While stalled (m_axis_tvalid=1, m_axis_tready=0), all stages and m_axis_tdata hold.
- Amplitude FSM:
  - IDLE → RAMP on amp handshake. Latch tgt_I/tgt_Q. step_X = (tgt_X − cur_X) >>> RAMP_LOG2, using 17-bit signed difference and truncated step. Clear ramp counter.
  - RAMP: on each accepted DDS sample (after it samples cur into stage 1), cur_X += step_X and the counter increments.
  - On the 2^RAMP_LOG2-th accepted sample, cur_X = tgt_X exactly (snap) and the FSM returns to IDLE.
  - RAMP_LOG2=0: cur loads target at the handshake and the FSM stays IDLE.
  - An amp update offered during RAMP is not accepted (tready=0) and waits.
  - Cycles without a DDS accept do not advance the ramp.
  - A DDS accept in the same cycle as the amp handshake uses the old cur. The ramp begins with the next accept.
- resync:
  - Clears pipeline valids, m_axis_tvalid, cur_I/cur_Q, and forces the FSM to IDLE.
  - The latched target is discarded.
  - Overrides a simultaneous DDS or amp handshake: both are ignored, and s_axis_*_tready=0 while resync=1.
- Async reset asserted mid-ramp or mid-stall returns all state to the reset values immediately.

Test Plan:
- Immediate load (RAMP_LOG2=0): amp I=16384, Q=0, then stream cos=32767, sin=0 → output 16384 exactly 3 cycles after each accept. Constant streaming gives tvalid every cycle.
- Quadrature: I=0, Q=16384, cos=0, sin=32767 → output −16384. With I=Q=16384, cos=sin=23170 → output 0.
- Saturation: I=−32768, Q=32767, cos=sin=−32768 → output 32767, no wrap. Negated product case → −32768.
- Ramp (RAMP_LOG2=4): cur 0 → target I=16384, cos=32767 constant → outputs step by 1024 per sample (0, 1024, …, 15360), then 16384 steady. ramp_busy is high for exactly 16 accepts. A second amp offered mid-ramp stays pending until IDLE, then is accepted.
- Backpressure: hold m_axis_tready=0 for 5 cycles mid-stream → m_axis_tdata stable, s_axis_dds_tready=0, no sample lost or duplicated. The ramp counter does not advance. The sequence matches the no-stall run.
- resync mid-ramp with tvalid=1 → next cycle m_axis_tvalid=0 and cur=0. The following samples output 0 until a new amp is loaded. Async reset mid-stall → all outputs 0 immediately.
